frac_mult_scheduler: RTL and testbench

- Shares one pipelined fixed-point fractional multiplier between N_REQ requesters using round-robin arbitration.
- Each requester has its own programmable quantized factor.
- Results return on a single tagged response stream with valid/ready backpressure.
- Sits between per-channel scaling clients (pixel/sample scalers) and downstream consumers, replacing N private multipliers.

---
 rtl/frac_mult_scheduler.sv | 149 ++++++++++++++
 tb/tb_frac_mult_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/frac_mult_scheduler.sv
// Round-robin shared fixed-point fractional multiplier with per-channel factors.
// Two-stage pipeline (product, rounded output) with tagged valid/ready response.
module frac_mult_scheduler #(
  parameter int N_REQ    = 4,
  parameter int IN_BIT   = 8,
  parameter int OUT_BIT  = 6,
  parameter int FRAC_BIT = 8,
  parameter int Q_BITS   = 16,
  parameter logic [Q_BITS-1:0] FACTOR_RESET = 16'h8000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(N_REQ)-1:0]   cfg_idx,
  input  logic [Q_BITS-1:0]          cfg_factor,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*IN_BIT-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [OUT_BIT-1:0]         rsp_dout,
  output logic [FRAC_BIT-1:0]        rsp_frac,
  output logic                       busy
);
  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = IN_BIT + Q_BITS;
  localparam int SH  = Q_BITS - FRAC_BIT;
  localparam int RW  = FRAC_BIT + IN_BIT + 1;

  logic [Q_BITS-1:0]   factor_q [N_REQ];
  logic [Q_BITS-1:0]   factor_d [N_REQ];
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic                s1_v_q, s1_v_d;
  logic [IDW-1:0]      s1_id_q, s1_id_d;
  logic [PW-1:0]       s1_p_q, s1_p_d;
  logic                s2_v_q, s2_v_d;
  logic [IDW-1:0]      s2_id_q, s2_id_d;
  logic [OUT_BIT-1:0]  s2_dout_q, s2_dout_d;
  logic [FRAC_BIT-1:0] s2_frac_q, s2_frac_d;

  logic                adv1, adv2, accept, gnt_found;
  logic [IDW-1:0]      gnt_idx;
  logic [IN_BIT-1:0]   gnt_data;
  logic [Q_BITS-1:0]   gnt_fac;
  logic [2*N_REQ-1:0]  rot;
  logic [RW-1:0]       rnd, rbit;
  logic                unused_bits;

  assign adv2   = !s2_v_q || rsp_ready;
  assign adv1   = !s1_v_q || adv2;
  assign accept = gnt_found && adv1 && !rst;

  // rotate so bit 0 is the channel just after the pointer
  always_comb begin
    rot       = {req_valid, req_valid} >> (int'(ptr_q) + 1);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found && rot[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(ptr_q) + 1 + k) % N_REQ);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    gnt_fac  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_data = req_data[i*IN_BIT +: IN_BIT];
        gnt_fac  = factor_q[i];
      end
    end
  end

  assign req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;

  if (SH > 0) begin : g_round
    assign rbit = RW'(s1_p_q[SH-1]);
  end else begin : g_exact
    assign rbit = '0;
  end
  assign rnd = RW'(s1_p_q >> SH) + rbit;

  always_comb begin
    factor_d  = factor_q;
    ptr_d     = ptr_q;
    s1_v_d    = s1_v_q;
    s1_id_d   = s1_id_q;
    s1_p_d    = s1_p_q;
    s2_v_d    = s2_v_q;
    s2_id_d   = s2_id_q;
    s2_dout_d = s2_dout_q;
    s2_frac_d = s2_frac_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (cfg_we && cfg_idx == IDW'(i)) factor_d[i] = cfg_factor;
    end
    if (accept) ptr_d = gnt_idx;
    if (adv1) begin
      s1_v_d = accept;
      if (accept) begin
        s1_id_d = gnt_idx;
        s1_p_d  = PW'(gnt_fac) * PW'(gnt_data);
      end
    end
    if (adv2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_id_d   = s1_id_q;
        s2_dout_d = rnd[FRAC_BIT +: OUT_BIT];
        s2_frac_d = rnd[FRAC_BIT-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) factor_q[i] <= FACTOR_RESET;
      ptr_q     <= IDW'(N_REQ - 1);
      s1_v_q    <= 1'b0;
      s1_id_q   <= '0;
      s1_p_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_id_q   <= '0;
      s2_dout_q <= '0;
      s2_frac_q <= '0;
    end else begin
      factor_q  <= factor_d;
      ptr_q     <= ptr_d;
      s1_v_q    <= s1_v_d;
      s1_id_q   <= s1_id_d;
      s1_p_q    <= s1_p_d;
      s2_v_q    <= s2_v_d;
      s2_id_q   <= s2_id_d;
      s2_dout_q <= s2_dout_d;
      s2_frac_q <= s2_frac_d;
    end
  end

  assign rsp_valid = s2_v_q;
  assign rsp_id    = s2_id_q;
  assign rsp_dout  = s2_dout_q;
  assign rsp_frac  = s2_frac_q;
  assign busy      = s1_v_q || s2_v_q;

  assign unused_bits = ^{rot, rnd, s1_p_q};
endmodule

// File: tb/tb_frac_mult_scheduler.sv
// Bench for frac_mult_scheduler: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_frac_mult_scheduler;
  localparam int N = 4, IB = 8, OB = 6, FB = 8, QB = 16, IDW = 2;
  localparam int SH = QB - FB;

  logic clk = 1'b0, rst = 1'b1, cfg_we = 1'b0;
  logic [IDW-1:0] cfg_idx = '0;
  logic [QB-1:0] cfg_factor = '0;
  logic [N-1:0] req_valid = '0;
  logic [N*IB-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic rsp_valid, rsp_ready = 1'b1, busy;
  logic [IDW-1:0] rsp_id;
  logic [OB-1:0] rsp_dout;
  logic [FB-1:0] rsp_frac;

  int checks = 0, errors = 0;
  typedef struct { int id; int dout; int frac; int age; } item_t;
  item_t mq[$];
  int mptr, last_acc;
  int mfac[N];
  bit auto_drop = 1'b0;

  always #5 clk = ~clk;

  frac_mult_scheduler #(
    .N_REQ(N), .IN_BIT(IB), .OUT_BIT(OB), .FRAC_BIT(FB),
    .Q_BITS(QB), .FACTOR_RESET(16'h8000)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_factor(cfg_factor), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_dout(rsp_dout), .rsp_frac(rsp_frac), .busy(busy)
  );

  task automatic chk(string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void mreset();
    mq.delete();
    mptr = N - 1;
    for (int i = 0; i < N; i++) mfac[i] = 32'h8000;
  endfunction

  // Grant the model expects: at most two results in flight,
  // a full pipe only moves when the consumer takes one.
  function automatic int mgrant();
    if (!(mq.size() < 2 || rsp_ready)) return -1;
    for (int k = 1; k <= N; k++)
      if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic setreq(int ch, bit v, int d);
    req_valid[ch] = v;
    req_data[ch*IB +: IB] = d[IB-1:0];
  endtask

  task automatic step();
    int g;
    bit vis, fire;
    longint p, r;
    item_t it;
    @(negedge clk);
    g = mgrant();
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'(1) << g) : 32'(0));
    vis = mq.size() > 0 && mq[0].age >= 1;
    chk("rsp_valid", 32'(rsp_valid), 32'(vis));
    if (vis) begin
      chk("rsp_id", 32'(rsp_id), mq[0].id);
      chk("rsp_dout", 32'(rsp_dout), mq[0].dout);
      chk("rsp_frac", 32'(rsp_frac), mq[0].frac);
    end
    chk("busy", 32'(busy), 32'(mq.size() > 0));
    fire = vis && rsp_ready;
    @(posedge clk);
    if (fire) void'(mq.pop_front());
    foreach (mq[i]) mq[i].age++;
    last_acc = g;
    if (g >= 0) begin
      p = longint'(mfac[g]) * longint'(req_data[g*IB +: IB]);
      r = (p >> SH) + ((p >> (SH - 1)) & 1);
      it.id = g;
      it.frac = int'(r % (1 << FB));
      it.dout = int'((r >> FB) % (1 << OB));
      it.age = 0;
      mq.push_back(it);
      mptr = g;
    end
    if (cfg_we) mfac[cfg_idx] = int'(cfg_factor);
    #1;
    if (auto_drop && last_acc >= 0) req_valid[last_acc] = 1'b0;
  endtask

  initial begin
    mreset();
    req_valid = '1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_dout", 32'(rsp_dout), 0);
    chk("rst_rsp_frac", 32'(rsp_frac), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // round robin, all channels requesting
    for (int i = 0; i < N; i++) setreq(i, 1'b1, $urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_order", last_acc, i % N);
    end
    req_valid = '0;
    repeat (3) step();

    // basic: 0.5 * 100
    setreq(0, 1'b1, 100);
    step();
    chk("basic_acc", last_acc, 0);
    setreq(0, 1'b0, 0);
    step();
    chk("basic_valid", 32'(rsp_valid), 1);
    chk("basic_id", 32'(rsp_id), 0);
    chk("basic_dout", 32'(rsp_dout), 50);
    chk("basic_frac", 32'(rsp_frac), 0);
    repeat (2) step();

    // rounding with factor 0x5555
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_factor = 16'h5555;
    step();
    cfg_we = 1'b0;
    setreq(1, 1'b1, 3);
    step();
    setreq(1, 1'b1, 1);
    step();
    setreq(1, 1'b0, 0);
    chk("round_dout", 32'(rsp_dout), 1);
    chk("round_frac", 32'(rsp_frac), 0);
    repeat (3) step();

    // factor write colliding with an accept on the same channel
    setreq(2, 1'b1, 40);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_factor = 16'h4000;
    step();
    cfg_we = 1'b0;
    step();
    setreq(2, 1'b0, 0);
    chk("coll_old_dout", 32'(rsp_dout), 20);
    step();
    chk("coll_new_dout", 32'(rsp_dout), 10);
    repeat (2) step();

    // backpressure
    for (int i = 0; i < N; i++) setreq(i, 1'b1, $urandom_range(0, 255));
    rsp_ready = 1'b0;
    repeat (5) step();
    chk("bp_ready_zero", 32'(req_ready), 0);
    chk("bp_busy", 32'(busy), 1);
    rsp_ready = 1'b1;
    auto_drop = 1'b1;
    repeat (10) step();
    chk("bp_drained", 32'(busy), 0);
    auto_drop = 1'b0;

    // reset with both stages full
    for (int i = 0; i < N; i++) setreq(i, 1'b1, $urandom_range(0, 255));
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_factor = 16'h1234;
    step();
    cfg_we = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) step();
    chk("mid_full", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_req_ready", 32'(req_ready), 0);
    mreset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    auto_drop = 1'b1;
    step();
    chk("post_rst_first", last_acc, 0);
    repeat (8) step();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_idx = IDW'($urandom_range(0, N - 1));
      cfg_factor = QB'($urandom);
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          setreq(i, 1'b1, $urandom_range(0, 255));
      step();
    end
    cfg_we = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) step();
    chk("final_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
